// File: rtl/id_exe_skid_stage.sv
// ---------------------------------------------------------------------------
// id_exe_skid_stage
//
// ID/EXE pipeline register with a valid/ready handshake and a two-entry skid
// buffer. It carries the decode-stage operands, immediate, next-PC, ALU opcode,
// destination register and control bundle into EXE. It can absorb
// back-pressure without dropping an instruction, and it can squash everything
// it holds into a bubble on a flush. It also keeps two saturating performance
// counters: cycles stalled by EXE, and cycles spent presenting a bubble.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   flush           squash held and incoming entries this cycle
//   in_valid        decode presents an instruction
//   in_ready        stage can accept (registered, equals !skid_v)
//   rdata1_in       source operand 1
//   rdata2_in       source operand 2
//   imm_in          sign-extended immediate
//   nPC_in          PC+1 of the instruction
//   opcode_in       ALU opcode
//   waddr_in        destination register
//   ctrl_in         {jal, memtoReg, memRead, memWrite, branch, wen}
//   out_valid       head entry valid towards EXE
//   out_ready       EXE consumes the head entry
//   *_out           head entry payload; ctrl_out is forced to 0 on a bubble
//   stall_cnt       cycles with out_valid=1 and out_ready=0, saturating
//   bubble_cnt      cycles with out_valid=0, saturating
// ---------------------------------------------------------------------------
module id_exe_skid_stage #(
  parameter int DSIZE  = 32,
  parameter int ASIZE  = 5,
  parameter int ISIZE  = 32,
  parameter int OPSIZE = 3,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DSIZE-1:0]  rdata1_in,
  input  logic [DSIZE-1:0]  rdata2_in,
  input  logic [DSIZE-1:0]  imm_in,
  input  logic [ISIZE-1:0]  nPC_in,
  input  logic [OPSIZE-1:0] opcode_in,
  input  logic [ASIZE-1:0]  waddr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DSIZE-1:0]  rdata1_out,
  output logic [DSIZE-1:0]  rdata2_out,
  output logic [DSIZE-1:0]  imm_out,
  output logic [ISIZE-1:0]  nPC_out,
  output logic [OPSIZE-1:0] opcode_out,
  output logic [ASIZE-1:0]  waddr_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // One payload record is all the fields that travel with an instruction.
  localparam int PW = 3*DSIZE + ISIZE + OPSIZE + ASIZE + CTRL_W;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic          main_v;
  logic          skid_v;
  logic [PW-1:0] main_pl;
  logic [PW-1:0] skid_pl;
  logic [PW-1:0] in_pl;

  logic          main_v_next;
  logic          skid_v_next;
  logic          load_main_in;
  logic          load_main_skid;
  logic          load_skid;

  logic          in_fire;
  logic          out_fire;

  // Pack the incoming fields into one record so main and skid are handled
  // uniformly; the unpack below on the output side uses the same order.
  assign in_pl = {rdata1_in, rdata2_in, imm_in, nPC_in, opcode_in, waddr_in, ctrl_in};

  // in_ready comes straight from the skid valid flop, so it never depends
  // combinationally on out_ready; a pop only reopens the input one cycle later.
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready;

  // Next-state selection for the two entries. Main always holds the oldest
  // instruction, so skid only ever feeds main, and a new instruction goes to
  // main only when main is empty or is being popped with skid empty.
  always_comb begin
    main_v_next    = main_v;
    skid_v_next    = skid_v;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush) begin
      main_v_next = 1'b0;
      skid_v_next = 1'b0;
    end else if (!main_v) begin
      if (in_fire) begin
        main_v_next  = 1'b1;
        load_main_in = 1'b1;
      end
    end else if (out_ready) begin
      if (skid_v) begin
        main_v_next    = 1'b1;
        load_main_skid = 1'b1;
        skid_v_next    = in_fire;
        load_skid      = in_fire;
      end else begin
        main_v_next  = in_fire;
        load_main_in = in_fire;
      end
    end else if (!skid_v && in_fire) begin
      skid_v_next = 1'b1;
      load_skid   = 1'b1;
    end
  end

  // Entry state and payload registers. Reset clears every payload so the
  // outputs read zero; a flush only drops the valid bits and leaves stale
  // payload behind, which is harmless because ctrl_out is gated by out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_pl <= '0;
      skid_pl <= '0;
    end else begin
      main_v <= main_v_next;
      skid_v <= skid_v_next;
      if (load_main_in) begin
        main_pl <= in_pl;
      end else if (load_main_skid) begin
        main_pl <= skid_pl;
      end
      if (load_skid) begin
        skid_pl <= in_pl;
      end
    end
  end

  // Performance counters look at the handshake as it stood before the edge,
  // including flush cycles, and stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v && !out_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (!main_v && bubble_cnt != CNT_MAX) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end

  // Unpack the head record. Data fields come straight from the main flops;
  // control is zeroed on a bubble so EXE never sees a stray write enable.
  logic [CTRL_W-1:0] main_ctrl;

  always_comb begin
    {rdata1_out, rdata2_out, imm_out, nPC_out, opcode_out, waddr_out, main_ctrl} = main_pl;
    ctrl_out = main_v ? main_ctrl : '0;
  end

endmodule
